// File: rtl/fifo_uart_tx_if.sv
// Read-side port of a show-ahead FIFO: head word, empty flag, and the pop strobe.
// The FIFO owns empty/data; the consumer owns rdack.
interface fifo_uart_tx_if #(
  parameter int N = 8
) ();
  logic         empty;
  logic [N-1:0] data;
  logic         rdack;

  modport master (output empty, output data, input rdack);
  modport slave  (input empty, input data, output rdack);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each word as start + N data bits (LSB first) + stop.
// Frames run back to back while words are available and en is high.
//
// state | meaning
// IDLE  | line idle high, waiting for en && !empty
// START | start bit (low) for DIV cycles
// DATA  | data bit shreg[0] for DIV cycles, N bits
// STOP  | stop bit (high) for DIV cycles, then reload or idle
module fifo_uart_tx #(
  parameter int N   = 8,
  parameter int DIV = 16
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           en,
  fifo_uart_tx_if.slave  fifo,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shreg_shr;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          rdack_q;
  logic          div_last;
  logic          load_ok;

  assign shreg_shr  = shreg >> 1;
  assign div_last   = (div_cnt == DIV_LAST);
  assign load_ok    = en && !fifo.empty;
  assign fifo.rdack = rdack_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      rdack_q <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rdack_q <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (load_ok) begin
            // Word is latched on this edge; the pop lands one edge later.
            shreg   <= fifo.data;
            rdack_q <= 1'b1;
            div_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DATA: begin
          if (div_last) begin
            div_cnt <= '0;
            shreg   <= shreg_shr;
            if (bit_cnt == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shreg_shr[0];
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        STOP: begin
          if (div_last) begin
            div_cnt <= '0;
            done    <= 1'b1;
            if (load_ok) begin
              shreg   <= fifo.data;
              rdack_q <= 1'b1;
              tx      <= 1'b0;
              busy    <= 1'b1;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for `fifo_sync`. It drains N-bit words from a show-ahead FIFO using the `empty`/`out`/`rdack` protocol and serialises each word as an asynchronous 8N1-style frame on `tx`: one start bit, N data bits LSB first, one stop bit. It sits between a CPU- or debug-side `fifo_sync` instance and the board serial pin. Frames go back to back, with no idle gap, while the FIFO has data.

## Interface
- `N`, default 8: data bits per frame; equals the FIFO word width.
- `DIV`, default 16: clk cycles per bit; legal range ≥ 2.
- `clk`  in  1  system clock.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `en`  in  1  start enable; gates only the start of a new frame.
- `empty`  in  1  FIFO empty flag.
- `data`  in  N  FIFO head word (show-ahead `out`).
- `rdack`  out  1  FIFO pop; one-cycle pulse per word consumed.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse after each stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP. `busy` = (state != IDLE), registered.
- Load decision:
  - Taken at a clock edge where state is IDLE, `en`=1 and `empty`=0.
  - Or at the last cycle of STOP under the same `en`/`empty` condition.
  - Action: shift register <= `data`; `rdack` <= 1 for exactly one cycle; state <= START; divider counter <= 0.
- The FIFO pops at the edge that ends the `rdack` cycle. The word has already been latched, so the pop never races the load.
- `rdack` is never asserted while `empty`=1. At most one pulse is issued per frame. This keeps the FIFO `underrun` flag at 0.
- START: `tx`=0 for DIV cycles, then DATA with bit counter = 0.
- DATA:
  - `tx` = shreg[0] for DIV cycles.
  - Then shift right one place and increment the bit counter.
  - After bit N-1 completes, go to STOP.
- STOP: `tx`=1 for DIV cycles.
  - At the last cycle, `done` <= 1 for one cycle.
  - Then either load the next word (back to back) or go to IDLE.
- Counter widths:
  - Divider: $clog2(DIV) bits; compares to DIV-1, no wrap beyond.
  - Bit counter: $clog2(N) bits (min 1); compares to N-1.
- `en`=0 mid-frame: the current frame completes normally. No new frame is loaded.
- `empty` or `data` changing mid-frame: ignored, because the shift register holds the word.
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: `tx`=1, `rdack`=0, `busy`=0, `done`=0.
  - Internal: state IDLE, shreg 0, counters 0.
  - The partial frame is dropped. The word it carried was already popped and is lost.

## Timing
- All outputs are registered; `tx` has no combinational path from inputs.
- Edge E0 = load decision edge in IDLE. After E0:
  - `tx`=0, `busy`=1, `rdack`=1 for cycle E0..E0+1.
  - Data bit k is driven from E0+(k+1)·DIV.
  - Stop bit is driven from E0+(N+1)·DIV.
  - `done` is high in the cycle starting E0+(N+2)·DIV.
- Frame length is exactly (N+2)·DIV cycles.
- Back to back:
  - Next start bit begins at E0+(N+2)·DIV, the same edge as `done`.
  - `tx` shows no idle cycle; `busy` stays 1.
- IDLE entry: when `empty`=1 or `en`=0 at the last STOP cycle, state is IDLE from E0+(N+2)·DIV. `busy`=0 in that cycle.
- Start latency from `empty` falling while IDLE: one edge, i.e. E0 is the first edge that samples `empty`=0.

## Test plan
- Reset with `empty`=0, `en`=1: `tx`=1, `rdack`=0, `busy`=0, `done`=0 during reset. First `rdack` comes at the first edge after release.
- N=8, DIV=4, one word 0xA5: `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total). Exactly one `rdack` pulse. `done` at cycle 40. `busy` falls at cycle 40.
- N=8, DIV=4, FIFO preloaded 0x00, 0xFF, 0x3C: 120 continuous `tx` cycles with no idle high gap between frames. 3 `rdack` pulses at cycles 0, 40 and 80. 3 `done` pulses. FIFO `underrun`/`overrun` stay 0.
- `en`=0 with `empty`=0: no `rdack` for 100 cycles and `tx`=1. Raise `en` to start a frame, then drop `en` at cycle 10: that frame completes (40 cycles) and no second frame starts.
- Assert `n_reset`=0 at cycle 15 of a 0x55 frame: `tx`=1 and `busy`=0 immediately. After release, the next FIFO word (not 0x55) is sent in full.
- DIV=2, N=5, word 0x1B: `tx` = 0,1,1,0,1,1,1, each held 2 cycles (14 total). `done` at cycle 14.
